// File: rtl/tap_prog_loader_pkg.sv
// Shared TAP/loader definitions: instruction encodings, RAM geometry, loader states
// and the CRC-32 word step used by the optional checksum (TAP_LOADER_CRC_EN).
package tap_prog_loader_pkg;

  localparam int INSTR_WIDTH    = 4;
  localparam int WORD_WIDTH     = 32;
  localparam int RAM_ADDR_WIDTH = 8;
  localparam int RAM_DEPTH      = 256;

  localparam logic [INSTR_WIDTH-1:0] IDCODE       = 4'b0001;
  localparam logic [INSTR_WIDTH-1:0] LOAD_PROGRAM = 4'b0011;
  localparam logic [INSTR_WIDTH-1:0] BYPASS       = 4'b1111;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } loader_state_t;

  // Non-reflected CRC-32, one data word consumed MSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/tap_loader_crc32.sv
// Combinational next-CRC for one 32-bit committed word; zero latency, no flow control.
module tap_loader_crc32
  import tap_prog_loader_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_next(crc_i, data_i);

endmodule

// File: rtl/tap_prog_loader.sv
// LOAD_PROGRAM sequencer: TDI -> 32-bit words -> instruction RAM, 1-cycle write latency,
// one-entry write buffer absorbs up to DATA_WIDTH-1 cycles of RAM backpressure. Optional CRC: TAP_LOADER_CRC_EN.
module tap_prog_loader
  import tap_prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int MEM_DEPTH  = RAM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   capture_dr_i,
  input  logic                   shift_dr_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  output logic                   ram_we_o,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic [DATA_WIDTH-1:0]  ram_wdata_o,
  input  logic                   ram_ready_i,
  output logic                   cpu_hold_o,
  output logic                   load_done_o,
  output logic [ADDR_WIDTH:0]    word_count_o,
  output logic                   overflow_o,
  output logic                   overrun_o,
  output logic [31:0]            crc_o
);

  localparam int                    CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  loader_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  buf_vld_q;
  logic [DATA_WIDTH-1:0] buf_dat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic                  overflow_q;
  logic                  overrun_q;

  logic                  in_load;
  logic                  enter_load;
  logic                  do_capture;
  logic                  do_shift;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  accept;
  logic                  buf_blocked;
  logic [ADDR_WIDTH:0]   claimed_cnt;
  logic                  mem_full;
  logic                  buf_load;

  assign in_load     = (state_q == ST_LOAD);
  assign enter_load  = (state_q == ST_IDLE) && (instr_i == LOAD_PROGRAM);
  assign do_capture  = in_load && capture_dr_i;
  assign do_shift    = in_load && shift_dr_i && !capture_dr_i;
  assign word_done   = do_shift && (bit_cnt_q == LAST_BIT);
  assign shift_nxt   = {tdi_i, shift_q[DATA_WIDTH-1:1]};
  assign accept      = buf_vld_q && ram_ready_i;
  assign buf_blocked = buf_vld_q && !ram_ready_i;

  // A word sitting in the buffer already owns a RAM slot, so count it when
  // deciding whether the memory is full; otherwise the last address is rewritten.
  assign claimed_cnt = word_cnt_q + (ADDR_WIDTH + 1)'(buf_vld_q);
  assign mem_full    = (claimed_cnt >= DEPTH_CNT);
  assign buf_load    = word_done && !buf_blocked && !mem_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (instr_i == LOAD_PROGRAM) state_d = ST_LOAD;
      ST_LOAD:  if (instr_i != LOAD_PROGRAM) state_d = ST_FLUSH;
      ST_FLUSH: if (!buf_vld_q || accept)    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      buf_vld_q  <= 1'b0;
      buf_dat_q  <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (enter_load) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (do_capture) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (do_shift) begin
        shift_q   <= shift_nxt;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
      end else if (!in_load) begin
        // Leaving LOAD throws away any partially shifted word.
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end

      if (accept) begin
        word_cnt_q <= word_cnt_q + (ADDR_WIDTH + 1)'(1);
        if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_WIDTH'(1);
      end

      if (word_done && buf_blocked)              overrun_q  <= 1'b1;
      if (word_done && !buf_blocked && mem_full) overflow_q <= 1'b1;

      if (buf_load) begin
        buf_vld_q <= 1'b1;
        buf_dat_q <= shift_nxt;
      end else if (accept) begin
        buf_vld_q <= 1'b0;
      end
    end
  end

  assign tdo_o        = in_load && shift_q[0];
  assign ram_we_o     = buf_vld_q;
  assign ram_addr_o   = addr_q;
  assign ram_wdata_o  = buf_dat_q;
  assign cpu_hold_o   = (state_q != ST_IDLE);
  assign load_done_o  = (state_q == ST_DONE);
  assign word_count_o = word_cnt_q;
  assign overflow_o   = overflow_q;
  assign overrun_o    = overrun_q;

`ifdef TAP_LOADER_CRC_EN
  logic [31:0] crc_q;
  logic [31:0] crc_step;

  tap_loader_crc32 u_crc32 (
    .crc_i  (crc_q),
    .data_i (32'(ram_wdata_o)),
    .crc_o  (crc_step)
  );

  // Only accepted writes advance the CRC, so it naturally freezes from DONE on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else if (enter_load) begin
      crc_q <= CRC_INIT;
    end else if (accept) begin
      crc_q <= crc_step;
    end
  end

  assign crc_o = crc_q;
`else
  assign crc_o = '0;
`endif

endmodule

// File: doc/tap_prog_loader.md
# tap_prog_loader

Sequencer behind the TAP LOAD_PROGRAM instruction. It deserializes TDI bits into 32-bit words and writes them into the 256-word instruction RAM with an auto-incrementing address. It holds the core in reset for the duration of the load and flags completion and error conditions. It sits between the TAP controller (single-cycle DR strobes already synchronized to the system clock) and the RAM write port.

## Interface
- DATA_WIDTH, 32, shifted word width and RAM write data width
- ADDR_WIDTH, 8, RAM address width
- MEM_DEPTH, 256, number of writable words; must equal 2**ADDR_WIDTH or less
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- instr_i  in  4  current TAP instruction register value
- capture_dr_i  in  1  one-cycle strobe, Capture-DR state
- shift_dr_i  in  1  one-cycle strobe, one TDI bit valid
- tdi_i  in  1  serial data in, sampled when shift_dr_i=1
- tdo_o  out  1  serial data out (shift register LSB)
- ram_we_o  out  1  write request, held until accepted
- ram_addr_o  out  ADDR_WIDTH  write address
- ram_wdata_o  out  DATA_WIDTH  write data
- ram_ready_i  in  1  RAM accepts write on this edge when ram_we_o=1
- cpu_hold_o  out  1  core held in reset
- load_done_o  out  1  one-cycle pulse at end of load
- word_count_o  out  ADDR_WIDTH+1  words committed this load
- overflow_o  out  1  sticky: word shifted beyond MEM_DEPTH
- overrun_o  out  1  sticky: word completed while previous write still pending
- crc_o  out  32  CRC-32 of committed words (see Configuration)

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD when instr_i==LOAD_PROGRAM. On entry: address, word_count, bit counter, overflow_o, overrun_o and CRC are cleared, and cpu_hold_o is set.
- LOAD, capture_dr_i: bit counter and shift register are cleared; the pending write is not affected.
- LOAD, shift_dr_i: shift register shifts right, tdi_i enters the MSB (LSB-first word), and the bit counter increments.
- On the DATA_WIDTH-th shift: the word goes into a one-entry write buffer and the bit counter returns to 0.
  - Buffer already full: word dropped, overrun_o set.
  - word_count_o == MEM_DEPTH: word dropped, overflow_o set.
- Accepted write (ram_we_o & ram_ready_i): address and word_count increment and the buffer empties. The address does not wrap. Words beyond MEM_DEPTH hit the overflow rule above.
- LOAD -> FLUSH when instr_i != LOAD_PROGRAM. Any partial word (bit counter != 0) is discarded.
- FLUSH -> DONE once the buffer is empty. DONE lasts one cycle: load_done_o=1, and cpu_hold_o is cleared on the DONE->IDLE edge.
- tdo_o = shift register bit 0 in LOAD, otherwise 0. The host therefore reads back its own data delayed by DATA_WIDTH bits.
- A capture_dr_i and shift_dr_i in the same cycle is illegal upstream. If it occurs, capture wins.

## Timing
- Reset values: all outputs 0, state IDLE, buffer empty, crc_o 0.
- ram_we_o rises on the edge after the clock in which the DATA_WIDTH-th shift_dr_i is sampled, giving 1-cycle latency.
- ram_we_o, ram_addr_o and ram_wdata_o are stable until ram_ready_i=1. ram_we_o drops on the accept edge unless a new word was buffered on that same edge.
- A write completing on the same edge as a new word completion is not an overrun.
- ram_ready_i held high gives a one-cycle write.
- Sustained throughput: one word per DATA_WIDTH shift strobes. The RAM has at most DATA_WIDTH-1 cycles of backpressure before an overrun.
- Reset asserted mid-load returns everything to reset values immediately: cpu_hold_o=0, no load_done_o pulse.
- word_count_o and the sticky flags stay valid in IDLE until the next LOAD entry.

## Configuration
- TAP_LOADER_CRC_EN defined:
  - crc_o holds a CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no final XOR, MSB-first over each word) updated on every accepted write.
  - crc_o is frozen from DONE until the next LOAD entry.
- TAP_LOADER_CRC_EN undefined: crc_o tied to 0 and no CRC logic is generated.

## Structure
- Shared package: the instruction encodings (LOAD_PROGRAM=4'b0011), instruction width, RAM address width, memory depth and data width, plus a new enum for the loader states. These are not redefined locally.
- One sub-module: tap_loader_crc32, a combinational next-CRC for a 32-bit word. It is instantiated only under TAP_LOADER_CRC_EN.

## Test plan
- Load 0x00000013 then 0xDEADBEEF, ram_ready_i=1, instr then set to BYPASS:
  - two writes: addr 0 = 0x00000013, addr 1 = 0xDEADBEEF;
  - word_count_o=2, one load_done_o pulse, cpu_hold_o low one cycle after the pulse.
- ram_ready_i low for 40 cycles after the first word while the second is shifted: overrun_o=1, the second word is dropped, and the first word is written once ready rises.
- Shift 257 words: addresses 0..255 are written, overflow_o=1 and word_count_o=256.
- Shift 20 bits, then capture_dr_i, then a full word 0xA5A5A5A5: only 0xA5A5A5A5 is written, at addr 0.
- Assert rst after 16 bits of the 3rd word: all outputs 0 on the next sample, no RAM write and no load_done_o.
- With TAP_LOADER_CRC_EN, load the single word 0x00000000: crc_o matches the reference model. Without the macro, crc_o stays 0.
